// File: rtl/seq_divider.sv
// Sequential restoring radix-2 divider for DIV/DIVU/MOD/MODU.
// Fixed latency of WIDTH+2 cycles from start to the done pulse.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             flush,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient_out,
    output logic [WIDTH-1:0] remainder_out
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] raw_a;
    logic             q_neg;
    logic             r_neg;
    logic             div0;

    logic             is_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   sh;
    logic [WIDTH-1:0] diff;
    logic             ge;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    // Op bit 0 selects the unsigned variants.
    assign is_signed = ~op[0];
    assign a_neg     = is_signed & dividend[WIDTH-1];
    assign b_neg     = is_signed & divisor[WIDTH-1];
    assign a_mag     = a_neg ? -dividend : dividend;
    assign b_mag     = b_neg ? -divisor : divisor;

    // Shifted remainder needs one extra bit before the compare.
    assign sh      = {rem, quo[WIDTH-1]};
    assign ge      = sh >= {1'b0, dvs};
    assign diff    = sh[WIDTH-1:0] - dvs;
    assign rem_nxt = ge ? diff : sh[WIDTH-1:0];

    assign q_fix = div0 ? '1 : (q_neg ? -quo : quo);
    assign r_fix = div0 ? raw_a : (r_neg ? -rem : rem);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            rem           <= '0;
            quo           <= '0;
            dvs           <= '0;
            raw_a         <= '0;
            q_neg         <= 1'b0;
            r_neg         <= 1'b0;
            div0          <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            quotient_out  <= '0;
            remainder_out <= '0;
        end else if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            cnt   <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= CALC;
                        busy  <= 1'b1;
                        cnt   <= '0;
                        rem   <= '0;
                        quo   <= a_mag;
                        dvs   <= b_mag;
                        raw_a <= dividend;
                        q_neg <= a_neg ^ b_neg;
                        r_neg <= a_neg;
                        div0  <= (divisor == '0);
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    rem <= rem_nxt;
                    quo <= {quo[WIDTH-2:0], ge};
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= FIX;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                FIX: begin
                    quotient_out  <= q_fix;
                    remainder_out <= r_fix;
                    done          <= 1'b1;
                    busy          <= 1'b0;
                    state         <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: directed ops, flush, reset, overlap.
// Expected results and done cycles are queued at issue, checked on done.
module tb_seq_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        flush;
    logic [1:0]  op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient_out;
    logic [31:0] remainder_out;

    int cyc = 0;
    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        int          c;
    } exp_t;

    exp_t sb[$];

    seq_divider #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .flush        (flush),
        .op           (op),
        .dividend     (dividend),
        .divisor      (divisor),
        .busy         (busy),
        .done         (done),
        .quotient_out (quotient_out),
        .remainder_out(remainder_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)",
                      name, act, exp, cyc);
    endtask

    // Monitor: every done pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_done: done=1 at cycle %0d, none expected",
                         cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("quotient", quotient_out, e.q);
                check("remainder", remainder_out, e.r);
                check("done_cycle", 32'(cyc), 32'(e.c));
            end
        end
    end

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input bit want,
                         input logic [31:0] qe, input logic [31:0] re);
        exp_t e;
        start    = 1'b1;
        op       = o;
        dividend = a;
        divisor  = b;
        if (want) begin
            e.q = qe;
            e.r = re;
            e.c = cyc + 34;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        start    = 1'b0;
        op       = 2'($urandom);
        dividend = $urandom;
        divisor  = $urandom;
    endtask

    task automatic do_op(input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] qe,
                         input logic [31:0] re);
        int t;
        t = cyc;
        issue(o, a, b, 1'b1, qe, re);
        goto(t + 35);
    endtask

    initial begin
        int t;
        int nb;
        rst      = 1'b1;
        start    = 1'b0;
        flush    = 1'b0;
        op       = 2'd0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_q", quotient_out, 32'd0);
        check("rst_r", remainder_out, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // DIVU 100/7 with busy window and done pulse width
        t = cyc;
        issue(2'b01, 32'd100, 32'd7, 1'b1, 32'd14, 32'd2);
        nb = 0;
        for (int k = 1; k <= 33; k++) begin
            goto(t + k);
            nb += int'(busy);
        end
        check("busy_cycles", 32'(nb), 32'd33);
        goto(t + 34);
        check("busy_in_done", 32'(busy), 32'd0);
        check("done_high", 32'(done), 32'd1);
        goto(t + 35);
        check("done_one_cycle", 32'(done), 32'd0);

        do_op(2'b00, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF);
        do_op(2'b10, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1);
        do_op(2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0);
        do_op(2'b01, 32'h12345678, 32'd0, 32'hFFFFFFFF, 32'h12345678);
        do_op(2'b10, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFF9);
        do_op(2'b11, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF, 32'hF);
        do_op(2'b00, 32'h80000000, 32'd2, 32'hC0000000, 32'd0);

        // Flush mid-op, then restart in the cycle after
        t = cyc;
        issue(2'b01, 32'd1000, 32'd3, 1'b0, '0, '0);
        goto(t + 10);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_hold_q", quotient_out, 32'hC0000000);
        check("flush_hold_r", remainder_out, 32'd0);
        issue(2'b00, 32'hFFFFFF9C, 32'd7, 1'b1, 32'hFFFFFFF2, 32'hFFFFFFFE);
        goto(t + 46);

        // Start coinciding with flush is dropped
        flush = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        start = 1'b0;
        check("flush_drops_start", 32'(busy), 32'd0);
        @(posedge clk);
        #1;

        // Start pulses while busy are ignored
        t = cyc;
        issue(2'b01, 32'd50, 32'd5, 1'b1, 32'd10, 32'd0);
        goto(t + 5);
        start = 1'b1; op = 2'b01; dividend = 32'd9; divisor = 32'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        goto(t + 20);
        start = 1'b1; op = 2'b01; dividend = 32'd9; divisor = 32'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        goto(t + 36);

        // Reset mid-op, start right after reset
        t = cyc;
        issue(2'b01, 32'd1000, 32'd3, 1'b0, '0, '0);
        goto(t + 15);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_q", quotient_out, 32'd0);
        check("midrst_r", remainder_out, 32'd0);
        issue(2'b01, 32'd9, 32'd2, 1'b1, 32'd4, 32'd1);
        goto(t + 51);

        // Back-to-back, second start in the DONE cycle
        t = cyc;
        issue(2'b01, 32'd81, 32'd9, 1'b1, 32'd9, 32'd0);
        goto(t + 34);
        issue(2'b11, 32'd17, 32'd5, 1'b1, 32'd3, 32'd2);
        goto(t + 50);
        check("b2b_hold_q", quotient_out, 32'd9);
        check("b2b_hold_r", remainder_out, 32'd0);
        check("b2b_busy", 32'(busy), 32'd1);
        goto(t + 69);

        t = cyc;
        while (sb.size() != 0 && cyc < t + 200) begin
            @(posedge clk);
            #1;
        end
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and result width.
REQ-002 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1: synchronous reset, active-high.
REQ-004 SHALL have port start  input  1: request from the EX stage; sampled only in IDLE or DONE.
REQ-005 SHALL have port flush  input  1: abort from pipeline control.
REQ-006 SHALL have port op  input  2: 00 DIV signed, 01 DIVU, 10 MOD signed, 11 MODU.
REQ-007 SHALL have port dividend  input  WIDTH: raw rj value, sampled with start.
REQ-008 SHALL have port divisor  input  WIDTH: raw rk value, sampled with start.
REQ-009 SHALL have port busy  output  1: high in CALC and FIX.
REQ-010 SHALL have port done  output  1: one-cycle completion pulse.
REQ-011 SHALL have port quotient_out  output  WIDTH: final quotient.
REQ-012 SHALL have port remainder_out  output  WIDTH: final remainder.

Function
REQ-013 SHALL implement the FSM states IDLE, CALC, FIX and DONE.
REQ-014 SHALL transition IDLE→CALC on start; in CALC, capture operands and op, take magnitudes for signed ops, and clear the iteration counter and partial remainder.
REQ-015 SHALL, in CALC, perform one restoring radix-2 step per cycle: shift the {remainder, quotient} pair left 1; subtract |divisor| when the shifted remainder is ≥ |divisor|; set the quotient LSB accordingly.
REQ-016 SHALL leave CALC for FIX after exactly WIDTH steps, with counter values 0..WIDTH-1 and no wrap.
REQ-017 SHALL, in FIX, apply signs and go to DONE: quotient negative iff the op is signed and the operand signs differ; remainder takes the dividend's sign; unsigned ops are unchanged.
REQ-018 SHALL drive done=1 only in DONE; DONE lasts one cycle, then goes to IDLE, or directly to CALC if start=1 in that cycle.
REQ-019 SHALL use fixed latency: start=1 in cycle t (IDLE) gives done=1 in cycle t+WIDTH+2 only, i.e. t+34 at WIDTH=32.
REQ-020 SHALL register quotient_out and remainder_out at the FIX→DONE edge and hold them until the next FIX→DONE edge.
REQ-021 SHALL ignore start while busy=1; no re-capture, no restart.
REQ-022 SHALL treat divisor==0 as follows: take the normal latency and produce quotient_out = all-ones and remainder_out = dividend as captured, for any op.
REQ-023 SHALL handle signed overflow (dividend=min-int, divisor=-1) by producing quotient_out = min-int and remainder_out = 0 at normal latency.
REQ-024 SHALL, on flush=1 in any state, go to IDLE at the next edge; no done is produced for the aborted op, and outputs keep their last values.
REQ-025 SHALL give rst priority over flush, and flush priority over start, when they coincide; start in the same cycle as flush is dropped.
REQ-026 SHALL keep results independent of dividend, divisor or op changing after capture.

Reset
REQ-027 SHALL, on rst=1 at a rising edge: state=IDLE, busy=0, done=0, quotient_out=0, remainder_out=0, counter=0.
REQ-028 SHALL abort any in-flight op on rst mid-operation, with no done afterwards; start is accepted in the first cycle after rst deasserts.

Verification
REQ-029 SHALL pass: DIVU 100/7, start at t → done only at t+34; q=14, r=2; busy high t+1..t+33.
REQ-030 SHALL pass: DIV 0xFFFFFFF9/2 (-7/2) → q=0xFFFFFFFD, r=0xFFFFFFFF; MOD 7/0xFFFFFFFE (7/-2) → r=1.
REQ-031 SHALL pass: DIV 0x80000000/0xFFFFFFFF → q=0x80000000, r=0; DIVU 0x12345678/0 → q=0xFFFFFFFF, r=0x12345678.
REQ-032 SHALL pass: start at t, flush at t+10 → busy=0 at t+11, no done through t+40; new start at t+11 → correct done at t+45.
REQ-033 SHALL pass: start pulses at t+5 and t+20 during an op → single done at t+34 with the first op's result; rst at t+15 → all outputs 0 at t+16, no done.
REQ-034 SHALL pass: back-to-back ops, with the second start in the DONE cycle t+34 → second done at t+68; the first results hold until then.
